// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target endpoint, 7-bit address, register pointer plus read/write data streaming
// Open-drain SDA is driven only from sda_low_q, which changes on synchronized SCL falling edges.

module i2c_target #(
   parameter logic [6:0] SLAVE_ADDR = 7'h42,
   parameter int         REG_ADDR_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  scl_pin,
   inout  wire                   sda_pin,
   output logic [REG_ADDR_W-1:0] reg_addr,
   output logic [7:0]            reg_wdata,
   output logic                  reg_wr_en,
   output logic                  reg_rd_en,
   input  logic [7:0]            reg_rdata,
   output logic                  busy,
   output logic                  transaction_done
);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
      S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_IGNORE
   } state_t;

   state_t state_q, state_d;

   logic scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d, scl_prev_q, scl_prev_d;
   logic sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d, sda_prev_q, sda_prev_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic [7:0]            shift_q, shift_d;
   logic                  sda_low_q, sda_low_d;
   logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_d;
   logic [7:0]            reg_wdata_q, reg_wdata_d;
   logic                  reg_wr_en_q, reg_wr_en_d;
   logic                  reg_rd_en_q, reg_rd_en_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic       scl_rise, scl_fall, start_det, stop_det, byte_done;
   logic [7:0] shift_in;
   logic [REG_ADDR_W-1:0] reg_addr_inc;

   assign scl_rise     = scl_sync_q & ~scl_prev_q;
   assign scl_fall     = ~scl_sync_q & scl_prev_q;
   assign start_det    = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
   assign stop_det     = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
   assign shift_in     = {shift_q[6:0], sda_sync_q};
   assign byte_done    = scl_rise && (bit_cnt_q == 4'd7);
   assign reg_addr_inc = reg_addr_q + {{(REG_ADDR_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scl_meta_q  <= 1'b1;
         scl_sync_q  <= 1'b1;
         scl_prev_q  <= 1'b1;
         sda_meta_q  <= 1'b1;
         sda_sync_q  <= 1'b1;
         sda_prev_q  <= 1'b1;
         bit_cnt_q   <= 4'd0;
         shift_q     <= 8'h00;
         sda_low_q   <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= 8'h00;
         reg_wr_en_q <= 1'b0;
         reg_rd_en_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         scl_meta_q  <= scl_meta_d;
         scl_sync_q  <= scl_sync_d;
         scl_prev_q  <= scl_prev_d;
         sda_meta_q  <= sda_meta_d;
         sda_sync_q  <= sda_sync_d;
         sda_prev_q  <= sda_prev_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         sda_low_q   <= sda_low_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_wr_en_q <= reg_wr_en_d;
         reg_rd_en_q <= reg_rd_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Bus conditions override any same-cycle SCL edge.
   always_comb begin
      state_d = state_q;
      if (start_det) begin
         state_d = S_ADDR;
      end else if (stop_det) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_ADDR:     if (byte_done) state_d = (shift_in[7:1] == SLAVE_ADDR) ? S_ADDR_ACK : S_IGNORE;
            S_ADDR_ACK: if (scl_fall && sda_low_q) state_d = shift_q[0] ? S_RD : S_PTR;
            S_PTR:      if (byte_done) state_d = S_PTR_ACK;
            S_PTR_ACK:  if (scl_fall && sda_low_q) state_d = S_WR;
            S_WR:       if (byte_done) state_d = S_WR_ACK;
            S_WR_ACK:   if (scl_fall && sda_low_q) state_d = S_WR;
            S_RD:       if (scl_fall && (bit_cnt_q == 4'd8)) state_d = S_RD_ACK;
            S_RD_ACK: begin
               if (scl_rise && sda_sync_q) state_d = S_IGNORE;
               else if (scl_fall)          state_d = S_RD;
            end
            default:    state_d = state_q;
         endcase
      end
   end

   always_comb begin
      scl_meta_d  = scl_pin;
      scl_sync_d  = scl_meta_q;
      scl_prev_d  = scl_sync_q;
      sda_meta_d  = sda_pin;
      sda_sync_d  = sda_meta_q;
      sda_prev_d  = sda_sync_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      sda_low_d   = sda_low_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_wr_en_d = 1'b0;
      reg_rd_en_d = 1'b0;
      busy_d      = busy_q;
      done_d      = 1'b0;
      if (start_det) begin
         bit_cnt_d = 4'd0;
         sda_low_d = 1'b0;
         busy_d    = 1'b0;
      end else if (stop_det) begin
         sda_low_d = 1'b0;
         busy_d    = 1'b0;
         done_d    = busy_q;
      end else begin
         case (state_q)
            S_ADDR, S_PTR, S_WR: begin
               if (scl_rise) begin
                  shift_d   = shift_in;
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
               if (byte_done && state_q == S_PTR) reg_addr_d = REG_ADDR_W'(shift_in);
               if (byte_done && state_q == S_WR) begin
                  reg_wdata_d = shift_in;
                  reg_wr_en_d = 1'b1;
               end
            end
            S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
               // First falling edge asserts the ACK, the second releases it.
               if (scl_fall && !sda_low_q) begin
                  sda_low_d = 1'b1;
                  if (state_q == S_ADDR_ACK) busy_d = 1'b1;
               end else if (scl_fall) begin
                  sda_low_d = 1'b0;
                  bit_cnt_d = 4'd0;
                  if (state_q == S_WR_ACK) reg_addr_d = reg_addr_inc;
                  if (state_q == S_ADDR_ACK && shift_q[0]) begin
                     shift_d     = reg_rdata;
                     reg_rd_en_d = 1'b1;
                     sda_low_d   = ~reg_rdata[7];
                     bit_cnt_d   = 4'd1;
                  end
               end
            end
            S_RD: begin
               if (scl_fall && bit_cnt_q == 4'd8) begin
                  sda_low_d = 1'b0;
               end else if (scl_fall) begin
                  shift_d   = {shift_q[6:0], 1'b0};
                  sda_low_d = ~shift_q[6];
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
            S_RD_ACK: begin
               if (scl_rise && !sda_sync_q) begin
                  reg_addr_d = reg_addr_inc;
               end else if (scl_fall) begin
                  shift_d     = reg_rdata;
                  reg_rd_en_d = 1'b1;
                  sda_low_d   = ~reg_rdata[7];
                  bit_cnt_d   = 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign sda_pin          = sda_low_q ? 1'b0 : 1'bz;
   assign reg_addr         = reg_addr_q;
   assign reg_wdata        = reg_wdata_q;
   assign reg_wr_en        = reg_wr_en_q;
   assign reg_rd_en        = reg_rd_en_q;
   assign busy             = busy_q;
   assign transaction_done = done_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - self-checking bench for i2c_target: vector table, corner sequences, random vs model
// The bench acts as bus master; the register file is a salted function of the address.

module tb_i2c_target;

   localparam int Q = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       scl;
   logic       m_low;
   wire        sda_line;
   logic [7:0] reg_addr, reg_wdata, reg_rdata, rd_salt;
   logic       reg_wr_en, reg_rd_en, busy, transaction_done;

   assign sda_line = m_low ? 1'b0 : 1'bz;
   pullup (sda_line);
   assign reg_rdata = reg_addr ^ rd_salt;

   i2c_target #(.SLAVE_ADDR(7'h42), .REG_ADDR_W(8)) dut (
      .clk              (clk),
      .reset            (reset),
      .scl_pin          (scl),
      .sda_pin          (sda_line),
      .reg_addr         (reg_addr),
      .reg_wdata        (reg_wdata),
      .reg_wr_en        (reg_wr_en),
      .reg_rd_en        (reg_rd_en),
      .reg_rdata        (reg_rdata),
      .busy             (busy),
      .transaction_done (transaction_done)
   );

   int checks = 0;
   int errors = 0;

   logic [15:0] wr_log[$];
   int rd_cnt = 0, done_cnt = 0, low_cnt = 0, viol = 0;
   logic dl_q = 1'b0, scl_q = 1'b1;

   // Observation point sits 2 ns after the active edge.
   always begin
      logic dl;
      @(posedge clk);
      #2;
      dl = (sda_line === 1'b0) && !m_low;
      if (reg_wr_en) wr_log.push_back({reg_addr, reg_wdata});
      if (reg_rd_en) rd_cnt++;
      if (transaction_done) done_cnt++;
      if (dl) low_cnt++;
      if (!reset && scl && scl_q && (dl != dl_q)) viol++;
      dl_q  = dl;
      scl_q = scl;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic wq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_low = 1'b0; wq();
      scl = 1'b1;   wq();
      m_low = 1'b1; wq();
      scl = 1'b0;   wq();
   endtask

   task automatic i2c_stop();
      m_low = 1'b1; wq();
      scl = 1'b1;   wq();
      m_low = 1'b0; wq();
   endtask

   task automatic put_bit(input bit b);
      m_low = !b; wq();
      scl = 1'b1; wq(); wq();
      scl = 1'b0; wq();
   endtask

   task automatic get_bit(output bit b);
      m_low = 1'b0; wq();
      scl = 1'b1;   wq();
      b = (sda_line !== 1'b0);
      wq();
      scl = 1'b0;   wq();
   endtask

   task automatic send_byte(input logic [7:0] d, output bit ack);
      bit b;
      for (int i = 7; i >= 0; i--) put_bit(d[i]);
      get_bit(b);
      ack = !b;
   endtask

   task automatic recv_byte(input bit ack, output logic [7:0] d);
      bit b;
      for (int i = 7; i >= 0; i--) begin
         get_bit(b);
         d[i] = b;
      end
      put_bit(!ack);
   endtask

   typedef struct {
      logic [31:0] bytes;
      int          nb;
      logic [3:0]  exp_ack;
      int          exp_nwr;
      logic [15:0] exp_w0;
      logic [15:0] exp_w1;
      int          exp_done;
   } vec_t;

   vec_t vecs[5];
   logic [7:0] m_ptr;

   task automatic run_random(input int kind);
      int wb, rb, db, n, k, exp_done;
      bit a;
      logic [7:0] p, d, ea;
      logic [15:0] exp_wr[$];
      wb = wr_log.size(); rb = rd_cnt; db = done_cnt;
      n = 0; exp_done = 1;
      i2c_start();
      if (kind == 0 || kind == 2) begin
         p = 8'($urandom);
         send_byte(8'h84, a); chk("rnd addr_w ack", a, 1);
         send_byte(p, a);     chk("rnd ptr ack", a, 1);
         m_ptr = p;
      end
      if (kind == 0) begin
         k = $urandom_range(0, 3);
         for (int i = 0; i < k; i++) begin
            d = 8'($urandom);
            exp_wr.push_back({m_ptr, d});
            send_byte(d, a); chk("rnd data ack", a, 1);
            m_ptr = m_ptr + 8'd1;
         end
      end
      if (kind == 1 || kind == 2) begin
         if (kind == 2) i2c_start();
         rd_salt = 8'($urandom);
         n = $urandom_range(1, 3);
         send_byte(8'h85, a); chk("rnd addr_r ack", a, 1);
         for (int i = 0; i < n; i++) begin
            recv_byte(i < n - 1, d);
            chk("rnd rdata", d, m_ptr ^ rd_salt);
            if (i < n - 1) m_ptr = m_ptr + 8'd1;
         end
      end
      if (kind == 3) begin
         exp_done = 0;
         ea = {7'($urandom), 1'($urandom)};
         if (ea[7:1] == 7'h42) ea[7:1] = 7'h43;
         send_byte(ea, a);           chk("rnd foreign ack", a, 0);
         send_byte(8'($urandom), a); chk("rnd foreign data ack", a, 0);
      end
      i2c_stop();
      wq();
      chk("rnd wr count", wr_log.size() - wb, exp_wr.size());
      if (wr_log.size() - wb == exp_wr.size())
         foreach (exp_wr[i]) chk("rnd wr entry", wr_log[wb + i], exp_wr[i]);
      chk("rnd rd_en count", rd_cnt - rb, n);
      chk("rnd done count", done_cnt - db, exp_done);
      chk("rnd busy idle", busy, 0);
   endtask

   initial begin
      bit a;
      logic [7:0] d0, d1;
      logic [3:0] acks;
      int wb, rb, db, lb;

      vecs[0] = '{32'h8410ABCD, 4, 4'b1111, 2, 16'h10AB, 16'h11CD, 1};
      vecs[1] = '{32'h86110000, 2, 4'b0000, 0, 16'h0000, 16'h0000, 0};
      vecs[2] = '{32'h84FF0102, 4, 4'b1111, 2, 16'hFF01, 16'h0002, 1};
      vecs[3] = '{32'h84000000, 1, 4'b0001, 0, 16'h0000, 16'h0000, 1};
      vecs[4] = '{32'h04550000, 2, 4'b0000, 0, 16'h0000, 16'h0000, 0};

      reset = 1'b1; scl = 1'b1; m_low = 1'b0; rd_salt = 8'h00;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("reset reg_addr", reg_addr, 8'h00);
      chk("reset reg_wdata", reg_wdata, 8'h00);
      chk("reset strobes", {reg_wr_en, reg_rd_en}, 2'b00);
      chk("reset busy/done", {busy, transaction_done}, 2'b00);
      chk("reset sda released", sda_line, 1'b1);

      foreach (vecs[v]) begin
         wb = wr_log.size(); db = done_cnt; lb = low_cnt;
         acks = 4'b0000;
         i2c_start();
         for (int i = 0; i < vecs[v].nb; i++) begin
            send_byte(vecs[v].bytes[31 - 8*i -: 8], a);
            acks[i] = a;
         end
         i2c_stop();
         wq();
         chk("tbl acks", acks, vecs[v].exp_ack);
         chk("tbl wr count", wr_log.size() - wb, vecs[v].exp_nwr);
         if (wr_log.size() - wb == vecs[v].exp_nwr && vecs[v].exp_nwr == 2) begin
            chk("tbl write 0", wr_log[wb], vecs[v].exp_w0);
            chk("tbl write 1", wr_log[wb + 1], vecs[v].exp_w1);
         end
         chk("tbl done count", done_cnt - db, vecs[v].exp_done);
         chk("tbl busy after", busy, 0);
         if (vecs[v].exp_ack == 4'b0000) chk("tbl foreign sda low", low_cnt - lb, 0);
      end

      // Combined read with repeated START
      rd_salt = 8'h5A;
      wb = wr_log.size(); rb = rd_cnt; db = done_cnt;
      i2c_start();
      send_byte(8'h84, a); chk("comb addr_w ack", a, 1);
      send_byte(8'h20, a); chk("comb ptr ack", a, 1);
      i2c_start();
      send_byte(8'h85, a); chk("comb addr_r ack", a, 1);
      recv_byte(1'b1, d0);
      recv_byte(1'b0, d1);
      i2c_stop();
      wq();
      chk("comb byte 0", d0, 8'h7A);
      chk("comb byte 1", d1, 8'h7B);
      chk("comb rd_en count", rd_cnt - rb, 2);
      chk("comb wr count", wr_log.size() - wb, 0);
      chk("comb done count", done_cnt - db, 1);

      // Early STOP inside a data byte, then a pointer-less read
      wb = wr_log.size(); db = done_cnt;
      i2c_start();
      send_byte(8'h84, a); chk("early addr ack", a, 1);
      send_byte(8'h30, a); chk("early ptr ack", a, 1);
      for (int i = 0; i < 4; i++) put_bit(i[0]);
      i2c_stop();
      wq();
      chk("early wr count", wr_log.size() - wb, 0);
      chk("early busy", busy, 0);
      chk("early sda released", sda_line, 1'b1);
      chk("early done count", done_cnt - db, 1);
      rd_salt = 8'hC3;
      i2c_start();
      send_byte(8'h85, a); chk("persist addr ack", a, 1);
      recv_byte(1'b0, d0);
      i2c_stop();
      wq();
      chk("persist rdata", d0, 8'h30 ^ 8'hC3);

      // Reset while the address ACK is held low
      i2c_start();
      for (int i = 7; i >= 0; i--) put_bit(i == 2 || i == 7);
      m_low = 1'b0;
      for (int i = 0; i < 20 && sda_line !== 1'b0; i++) @(negedge clk);
      chk("rst ack held", sda_line, 1'b0);
      wb = wr_log.size(); rb = rd_cnt;
      reset = 1'b1;
      @(negedge clk);
      chk("rst sda released", sda_line, 1'b1);
      chk("rst reg_addr", reg_addr, 8'h00);
      chk("rst outputs", {reg_wdata, reg_wr_en, reg_rd_en, busy, transaction_done}, 12'h000);
      reset = 1'b0;
      @(negedge clk);
      i2c_stop();
      i2c_start();
      send_byte(8'h84, a); chk("post-rst addr ack", a, 1);
      send_byte(8'h05, a); chk("post-rst ptr ack", a, 1);
      send_byte(8'h99, a); chk("post-rst data ack", a, 1);
      i2c_stop();
      wq();
      chk("post-rst wr count", wr_log.size() - wb, 1);
      if (wr_log.size() - wb == 1) chk("post-rst write", wr_log[wb], 16'h0599);
      chk("post-rst rd_en", rd_cnt - rb, 0);

      m_ptr = 8'h00;
      for (int t = 0; t < 16; t++) run_random((t == 0) ? 0 : int'($urandom_range(0, 3)));

      chk("sda change while scl high", viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
